// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with runtime limit, saturate/wrap handling, load and boundary pulses.
// Optional step prescaler is built only when COUNTER_PRESCALE_EN is defined.
module param_updown_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP     = 1,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             wrap_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_limit,
    output logic             wrap_evt,
    output logic             sat_evt
);

    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

    if (WIDTH < 2) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be >= 2");
    end
    if (STEP == 0 || (WIDTH < 32 && STEP > (32'd1 << WIDTH) - 32'd1)) begin : g_bad_step
        $error("param_updown_counter: STEP out of range");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("param_updown_counter: PRESCALE must be >= 1");
    end

    logic             over_limit;
    logic             tick;
    logic [WIDTH:0]   headroom;
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             sat_next;

    assign over_limit = count > limit;
    // Only meaningful when count <= limit; the extra bit keeps the subtraction exact.
    assign headroom   = {1'b0, limit} - {1'b0, count};

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] presc;

    assign tick = (presc == PS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (load || (enable && over_limit)) begin
            presc <= '0;
        end else if (enable) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        sat_next   = 1'b0;
        if (load) begin
            count_next = (load_value > limit) ? limit : load_value;
        end else if (enable) begin
            if (over_limit) begin
                count_next = limit;
            end else if (tick) begin
                if (up_down) begin
                    if (headroom >= STEP_X) begin
                        count_next = count + STEP_N;
                    end else if (wrap_mode) begin
                        count_next = '0;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = limit;
                        sat_next   = 1'b1;
                    end
                end else begin
                    if ({1'b0, count} >= STEP_X) begin
                        count_next = count - STEP_N;
                    end else if (wrap_mode) begin
                        count_next = limit;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = '0;
                        sat_next   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            wrap_evt <= 1'b0;
            sat_evt  <= 1'b0;
        end else begin
            count    <= count_next;
            wrap_evt <= wrap_next;
            sat_evt  <= sat_next;
        end
    end

    assign at_zero  = (count == '0);
    assign at_limit = (count == limit);

endmodule
